// File: rtl/gem_xlat_pkg.sv
// Shared constants, FSM encoding and result record for the GEM cluster translator scheduler.
package gem_xlat_pkg;

  localparam int MXCLST   = 8;
  localparam int SLOTB    = 3;
  localparam int CLSTB    = 14;
  localparam int WIREBITS = 7;
  localparam int MXXKYB   = 10;

  // Field positions inside a cluster word
  localparam int PAD_LSB  = 0;
  localparam int ROLL_LSB = 8;
  localparam int SIZE_LSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One translated slot as returned by the shared translator
  typedef struct packed {
    logic                vpf;
    logic                me1a;
    logic [WIREBITS-1:0] wire_lo;
    logic [WIREBITS-1:0] wire_hi;
    logic [WIREBITS-1:0] wire_mi;
    logic [MXXKYB-1:0]   xky_lo;
    logic [MXXKYB-1:0]   xky_hi;
    logic [MXXKYB-1:0]   xky_mi;
  } res_rec_t;

endpackage

// File: rtl/gem_xlat_slot_pipe.sv
// Delay line that follows each issued slot index through the translator latency.
module gem_xlat_slot_pipe #(
  parameter int LAT   = 1,
  parameter int SLOTB = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_vld,
  input  logic [SLOTB-1:0] push_slot,
  output logic             tail_vld,
  output logic [SLOTB-1:0] tail_slot,
  output logic             inflight
);

  logic [LAT-1:0]   vld;
  logic [SLOTB-1:0] slot [LAT];

  // Shift valid flag and slot index one stage per clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) slot[i] <= '0;
    end else begin
      vld[0]  <= push_vld;
      slot[0] <= push_slot;
      for (int i = 1; i < LAT; i++) begin
        vld[i]  <= vld[i-1];
        slot[i] <= slot[i-1];
      end
    end
  end

  assign tail_vld  = vld[LAT-1];
  assign tail_slot = slot[LAT-1];

  // Entries still in flight after the tail leaves on the coming edge
  generate
    if (LAT > 1) begin : g_deep
      assign inflight = |vld[LAT-2:0];
    end else begin : g_single
      assign inflight = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/gem_cluster_xlat_sched.sv
// Time-multiplexes one GEM cluster translator over the clusters captured in a BX
// and scatters the returned windows back into per-slot result registers.
module gem_cluster_xlat_sched import gem_xlat_pkg::*; #(
  parameter int XLAT_LAT = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       bx_start,
  input  logic [MXCLST*CLSTB-1:0]    clst_in,
  input  logic [MXCLST-1:0]          clst_vpf_in,
  output logic [CLSTB-1:0]           xl_cluster,
  output logic                       xl_vpf,
  output logic [2:0]                 xl_roll,
  output logic [7:0]                 xl_pad,
  output logic [2:0]                 xl_size,
  input  logic                       xl_vpf_ret,
  input  logic                       xl_me1a,
  input  logic [WIREBITS-1:0]        xl_wire_lo,
  input  logic [WIREBITS-1:0]        xl_wire_hi,
  input  logic [WIREBITS-1:0]        xl_wire_mi,
  input  logic [MXXKYB-1:0]          xl_xky_lo,
  input  logic [MXXKYB-1:0]          xl_xky_hi,
  input  logic [MXXKYB-1:0]          xl_xky_mi,
  output logic [MXCLST-1:0]          res_vpf,
  output logic [MXCLST-1:0]          res_me1a,
  output logic [MXCLST*WIREBITS-1:0] res_wire_lo,
  output logic [MXCLST*WIREBITS-1:0] res_wire_hi,
  output logic [MXCLST*WIREBITS-1:0] res_wire_mi,
  output logic [MXCLST*MXXKYB-1:0]   res_xky_lo,
  output logic [MXCLST*MXXKYB-1:0]   res_xky_hi,
  output logic [MXCLST*MXXKYB-1:0]   res_xky_mi,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 overrun_cnt
);

  state_t            state, state_next;
  logic [CLSTB-1:0]  slot_word [MXCLST];
  logic [MXCLST-1:0] pending, pending_next;
  logic [SLOTB-1:0]  sel;
  logic              issue;
  logic              accept;
  logic              tail_vld;
  logic [SLOTB-1:0]  tail_slot;
  logic              inflight;
  res_rec_t          res [MXCLST];
  res_rec_t          ret_rec;

  assign accept = bx_start && ((state == ST_IDLE) || (state == ST_DONE));

  // Lowest pending slot wins the translator this cycle
  always_comb begin
    sel = '0;
    for (int i = MXCLST - 1; i >= 0; i--) begin
      if (pending[i]) sel = SLOTB'(i);
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next state, pending-mask update and status outputs
  always_comb begin
    state_next   = state;
    pending_next = pending;
    issue        = 1'b0;
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bx_start) begin
          pending_next = clst_vpf_in;
          state_next   = (clst_vpf_in != '0) ? ST_ISSUE : ST_DONE;
        end else if (state == ST_DONE) begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issue             = 1'b1;
        pending_next[sel] = 1'b0;
        if (pending_next == '0) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!inflight) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Translator request is driven only while issuing
  assign xl_vpf     = issue;
  assign xl_cluster = issue ? slot_word[sel] : '0;
  assign xl_pad     = xl_cluster[PAD_LSB  +: 8];
  assign xl_roll    = xl_cluster[ROLL_LSB +: 3];
  assign xl_size    = xl_cluster[SIZE_LSB +: 3];

  gem_xlat_slot_pipe #(
    .LAT   (XLAT_LAT),
    .SLOTB (SLOTB)
  ) u_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .push_vld  (issue),
    .push_slot (sel),
    .tail_vld  (tail_vld),
    .tail_slot (tail_slot),
    .inflight  (inflight)
  );

  // Gather the translator return into one record
  always_comb begin
    ret_rec         = '0;
    ret_rec.vpf     = xl_vpf_ret;
    ret_rec.me1a    = xl_me1a;
    ret_rec.wire_lo = xl_wire_lo;
    ret_rec.wire_hi = xl_wire_hi;
    ret_rec.wire_mi = xl_wire_mi;
    ret_rec.xky_lo  = xl_xky_lo;
    ret_rec.xky_hi  = xl_xky_hi;
    ret_rec.xky_mi  = xl_xky_mi;
  end

  // Slot capture, pending mask, result scatter and overrun counting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= '0;
      overrun_cnt <= '0;
      for (int i = 0; i < MXCLST; i++) begin
        slot_word[i] <= '0;
        res[i]       <= '0;
      end
    end else begin
      pending <= pending_next;
      if (accept) begin
        for (int i = 0; i < MXCLST; i++) begin
          slot_word[i] <= clst_in[i*CLSTB +: CLSTB];
          res[i]       <= '0;
        end
      end else if (tail_vld) begin
        res[tail_slot] <= ret_rec;
      end
      if (bx_start && !accept && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  // Flatten per-slot records onto the packed result ports
  generate
    for (genvar gi = 0; gi < MXCLST; gi++) begin : g_res
      assign res_vpf[gi]                           = res[gi].vpf;
      assign res_me1a[gi]                          = res[gi].me1a;
      assign res_wire_lo[gi*WIREBITS +: WIREBITS]  = res[gi].wire_lo;
      assign res_wire_hi[gi*WIREBITS +: WIREBITS]  = res[gi].wire_hi;
      assign res_wire_mi[gi*WIREBITS +: WIREBITS]  = res[gi].wire_mi;
      assign res_xky_lo[gi*MXXKYB +: MXXKYB]       = res[gi].xky_lo;
      assign res_xky_hi[gi*MXXKYB +: MXXKYB]       = res[gi].xky_hi;
      assign res_xky_mi[gi*MXXKYB +: MXXKYB]       = res[gi].xky_mi;
    end
  endgenerate

endmodule

// File: tb/tb_gem_cluster_xlat_sched.sv
// Bench: two schedulers (translator latency 1 and 3) share stimulus; each has its own
// translator model, and a slot-order/latency reference predicts every cycle.
module tb_gem_cluster_xlat_sched;
  import gem_xlat_pkg::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int TQW   = CLSTB + 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                    reset_n;
  logic                    bx_start;
  logic [MXCLST*CLSTB-1:0] clst_in;
  logic [MXCLST-1:0]       clst_vpf_in;

  logic [CLSTB-1:0] xl_cluster_a, xl_cluster_b;
  logic             xl_vpf_a, xl_vpf_b;
  logic [2:0]       xl_roll_a, xl_roll_b, xl_size_a, xl_size_b;
  logic [7:0]       xl_pad_a, xl_pad_b;
  logic [MXCLST-1:0] res_vpf_a, res_vpf_b, res_me1a_a, res_me1a_b;
  logic [MXCLST*WIREBITS-1:0] rwl_a, rwh_a, rwm_a, rwl_b, rwh_b, rwm_b;
  logic [MXCLST*MXXKYB-1:0]   rkl_a, rkh_a, rkm_a, rkl_b, rkh_b, rkm_b;
  logic busy_a, busy_b, done_a, done_b;
  logic [7:0] overrun_a, overrun_b;

  res_rec_t ret_a, ret_b;
  logic [TQW-1:0]   tq_a;
  logic [3*TQW-1:0] tq_b;

  int checks, errors, cyc, ovr_exp;
  logic [MXCLST*CLSTB-1:0] cur_w;
  logic [MXCLST-1:0]       cur_m;

  // Translator behaviour: any function of the cluster word, valid gated off for roll 7
  function automatic res_rec_t xlat(input logic [TQW-1:0] t);
    res_rec_t r;
    logic [7:0] pad;
    logic [2:0] roll, size;
    pad  = t[7:0];
    roll = t[10:8];
    size = t[13:11];
    r = '0;
    if (t[CLSTB]) begin
      r.vpf     = (roll != 3'd7);
      r.me1a    = roll[2];
      r.wire_lo = {roll, 1'b0, size};
      r.wire_hi = pad[7:1];
      r.wire_mi = pad[6:0] ^ 7'h55;
      r.xky_lo  = {2'b00, pad};
      r.xky_hi  = {2'b00, pad} + {7'd0, size};
      r.xky_mi  = {roll, pad[6:0]};
    end
    return r;
  endfunction

  // Translator latency models
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tq_a <= '0;
      tq_b <= '0;
    end else begin
      tq_a <= {xl_vpf_a, xl_cluster_a};
      tq_b <= {tq_b[2*TQW-1:0], xl_vpf_b, xl_cluster_b};
    end
  end
  assign ret_a = xlat(tq_a);
  assign ret_b = xlat(tq_b[3*TQW-1 -: TQW]);

  gem_cluster_xlat_sched #(.XLAT_LAT(LAT_A)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .bx_start(bx_start), .clst_in(clst_in), .clst_vpf_in(clst_vpf_in),
    .xl_cluster(xl_cluster_a), .xl_vpf(xl_vpf_a), .xl_roll(xl_roll_a), .xl_pad(xl_pad_a), .xl_size(xl_size_a),
    .xl_vpf_ret(ret_a.vpf), .xl_me1a(ret_a.me1a),
    .xl_wire_lo(ret_a.wire_lo), .xl_wire_hi(ret_a.wire_hi), .xl_wire_mi(ret_a.wire_mi),
    .xl_xky_lo(ret_a.xky_lo), .xl_xky_hi(ret_a.xky_hi), .xl_xky_mi(ret_a.xky_mi),
    .res_vpf(res_vpf_a), .res_me1a(res_me1a_a),
    .res_wire_lo(rwl_a), .res_wire_hi(rwh_a), .res_wire_mi(rwm_a),
    .res_xky_lo(rkl_a), .res_xky_hi(rkh_a), .res_xky_mi(rkm_a),
    .busy(busy_a), .done(done_a), .overrun_cnt(overrun_a)
  );

  gem_cluster_xlat_sched #(.XLAT_LAT(LAT_B)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .bx_start(bx_start), .clst_in(clst_in), .clst_vpf_in(clst_vpf_in),
    .xl_cluster(xl_cluster_b), .xl_vpf(xl_vpf_b), .xl_roll(xl_roll_b), .xl_pad(xl_pad_b), .xl_size(xl_size_b),
    .xl_vpf_ret(ret_b.vpf), .xl_me1a(ret_b.me1a),
    .xl_wire_lo(ret_b.wire_lo), .xl_wire_hi(ret_b.wire_hi), .xl_wire_mi(ret_b.wire_mi),
    .xl_xky_lo(ret_b.xky_lo), .xl_xky_hi(ret_b.xky_hi), .xl_xky_mi(ret_b.xky_mi),
    .res_vpf(res_vpf_b), .res_me1a(res_me1a_b),
    .res_wire_lo(rwl_b), .res_wire_hi(rwh_b), .res_wire_mi(rwm_b),
    .res_xky_lo(rkl_b), .res_xky_hi(rkh_b), .res_xky_mi(rkm_b),
    .busy(busy_b), .done(done_b), .overrun_cnt(overrun_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [MXCLST*CLSTB-1:0] rand_words();
    logic [MXCLST*CLSTB-1:0] w;
    for (int s = 0; s < MXCLST; s++) w[s*CLSTB +: CLSTB] = CLSTB'($urandom);
    return w;
  endfunction

  task automatic apply_bx(input logic [MXCLST*CLSTB-1:0] w, input logic [MXCLST-1:0] m);
    bx_start    = 1'b1;
    clst_in     = w;
    clst_vpf_in = m;
    cur_w       = w;
    cur_m       = m;
  endtask

  // Expected results: every valid slot holds its own translation, others stay zero
  task automatic cmp_res(input string who, input logic [7:0] vpf, input logic [7:0] me1a,
                         input logic [55:0] wl, input logic [55:0] wh, input logic [55:0] wm,
                         input logic [79:0] kl, input logic [79:0] kh, input logic [79:0] km);
    logic [7:0]  ev, em;
    logic [55:0] ewl, ewh, ewm;
    logic [79:0] ekl, ekh, ekm;
    res_rec_t r;
    for (int s = 0; s < MXCLST; s++) begin
      r = cur_m[s] ? xlat({1'b1, cur_w[s*CLSTB +: CLSTB]}) : '0;
      ev[s] = r.vpf;
      em[s] = r.me1a;
      ewl[s*7 +: 7] = r.wire_lo;
      ewh[s*7 +: 7] = r.wire_hi;
      ewm[s*7 +: 7] = r.wire_mi;
      ekl[s*10 +: 10] = r.xky_lo;
      ekh[s*10 +: 10] = r.xky_hi;
      ekm[s*10 +: 10] = r.xky_mi;
    end
    chk({"res_vpf_", who},     128'(vpf),  128'(ev));
    chk({"res_me1a_", who},    128'(me1a), 128'(em));
    chk({"res_wire_lo_", who}, 128'(wl),   128'(ewl));
    chk({"res_wire_hi_", who}, 128'(wh),   128'(ewh));
    chk({"res_wire_mi_", who}, 128'(wm),   128'(ewm));
    chk({"res_xky_lo_", who},  128'(kl),   128'(ekl));
    chk({"res_xky_hi_", who},  128'(kh),   128'(ekh));
    chk({"res_xky_mi_", who},  128'(km),   128'(ekm));
  endtask

  // Walk one accepted set cycle by cycle; optionally load the next set in the final DONE cycle
  task automatic run_cycles(input logic [15:0] ovr_mask, input bit chain,
                            input logic [MXCLST*CLSTB-1:0] nw, input logic [MXCLST-1:0] nm);
    int ord[$];
    int n, last, dca, dcb;
    logic [CLSTB-1:0] ec;
    logic [127:0] rnd;
    for (int s = 0; s < MXCLST; s++) if (cur_m[s]) ord.push_back(s);
    n    = ord.size();
    dca  = (n == 0) ? 1 : n + LAT_A + 1;
    dcb  = (n == 0) ? 1 : n + LAT_B + 1;
    last = dcb;
    for (int c = 1; c <= last; c++) begin
      @(posedge clock); #1;
      cyc         = c;
      rnd         = {$urandom, $urandom, $urandom, $urandom};
      bx_start    = ovr_mask[c];
      clst_in     = rnd[MXCLST*CLSTB-1:0];
      clst_vpf_in = 8'($urandom);
      ec = (c <= n) ? cur_w[ord[c-1]*CLSTB +: CLSTB] : '0;
      chk("xl_vpf_a",     128'(xl_vpf_a),     128'(c <= n));
      chk("xl_vpf_b",     128'(xl_vpf_b),     128'(c <= n));
      chk("xl_cluster_a", 128'(xl_cluster_a), 128'(ec));
      chk("xl_cluster_b", 128'(xl_cluster_b), 128'(ec));
      chk("xl_fields_a",  128'({xl_size_a, xl_roll_a, xl_pad_a}), 128'(ec));
      chk("xl_fields_b",  128'({xl_size_b, xl_roll_b, xl_pad_b}), 128'(ec));
      chk("done_a",       128'(done_a),       128'(c == dca));
      chk("done_b",       128'(done_b),       128'(c == dcb));
      chk("busy_a",       128'(busy_a),       128'(c <= dca));
      chk("busy_b",       128'(busy_b),       128'(c <= dcb));
      chk("overrun_a",    128'(overrun_a),    128'(ovr_exp));
      chk("overrun_b",    128'(overrun_b),    128'(ovr_exp));
      if (ovr_mask[c] && ovr_exp < 255) ovr_exp++;
      if (c == last) begin
        cmp_res("a", res_vpf_a, res_me1a_a, rwl_a, rwh_a, rwm_a, rkl_a, rkh_a, rkm_a);
        cmp_res("b", res_vpf_b, res_me1a_b, rwl_b, rwh_b, rwm_b, rkl_b, rkh_b, rkm_b);
        $display("set mask=%02h slots=%0d done_a=%0d done_b=%0d overrun=%0d", cur_m, n, dca, dcb, ovr_exp);
        if (chain) apply_bx(nw, nm);
      end
    end
  endtask

  task automatic do_set(input logic [MXCLST*CLSTB-1:0] w, input logic [MXCLST-1:0] m,
                        input logic [15:0] ovr_mask);
    @(posedge clock); #1;
    apply_bx(w, m);
    run_cycles(ovr_mask, 1'b0, '0, '0);
  endtask

  task automatic chk_quiet(input string who);
    chk({"rst_busy_a_", who},  128'(busy_a),    128'(0));
    chk({"rst_busy_b_", who},  128'(busy_b),    128'(0));
    chk({"rst_done_a_", who},  128'(done_a),    128'(0));
    chk({"rst_done_b_", who},  128'(done_b),    128'(0));
    chk({"rst_xlvpf_a_", who}, 128'(xl_vpf_a),  128'(0));
    chk({"rst_xlvpf_b_", who}, 128'(xl_vpf_b),  128'(0));
    chk({"rst_xlcl_a_", who},  128'(xl_cluster_a), 128'(0));
    chk({"rst_xlcl_b_", who},  128'(xl_cluster_b), 128'(0));
  endtask

  task automatic chk_cleared(input string who);
    chk_quiet(who);
    chk({"rst_res_vpf_a_", who}, 128'(res_vpf_a), 128'(0));
    chk({"rst_res_vpf_b_", who}, 128'(res_vpf_b), 128'(0));
    chk({"rst_res_xky_a_", who}, 128'(rkl_a | rkh_a | rkm_a), 128'(0));
    chk({"rst_res_xky_b_", who}, 128'(rkl_b | rkh_b | rkm_b), 128'(0));
    chk({"rst_res_wire_a_", who}, 128'(rwl_a | rwh_a | rwm_a | 56'(res_me1a_a)), 128'(0));
    chk({"rst_res_wire_b_", who}, 128'(rwl_b | rwh_b | rwm_b | 56'(res_me1a_b)), 128'(0));
    chk({"rst_ovr_a_", who}, 128'(overrun_a), 128'(0));
    chk({"rst_ovr_b_", who}, 128'(overrun_b), 128'(0));
  endtask

  initial begin
    logic [MXCLST*CLSTB-1:0] w, wb;
    checks = 0; errors = 0; cyc = 0; ovr_exp = 0;
    reset_n = 1'b0; bx_start = 1'b0; clst_in = '0; clst_vpf_in = '0;
    cur_w = '0; cur_m = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk_cleared("init");
    reset_n = 1'b1;

    // Directed: slots 0,2,7 with pad = slot*16
    for (int s = 0; s < MXCLST; s++) w[s*CLSTB +: CLSTB] = {3'd1, 3'(s & 3), 8'(s * 16)};
    do_set(w, 8'h85, 16'h0000);
    chk("dir_xky_lo_s0", 128'(rkl_a[0*10 +: 10]), 128'(0));
    chk("dir_xky_lo_s2", 128'(rkl_a[2*10 +: 10]), 128'(32));
    chk("dir_xky_lo_s7", 128'(rkl_a[7*10 +: 10]), 128'(112));
    chk("dir_res_vpf",   128'(res_vpf_a),          128'(8'h85));

    // Empty set: DONE right away, nothing issued
    do_set(rand_words(), 8'h00, 16'h0000);

    // Full set with overruns in cycles 2 and 4, then a set loaded in the DONE cycle
    // whose slot 3 carries roll 7 (translator reports it invalid)
    wb = rand_words();
    for (int s = 0; s < MXCLST; s++)
      wb[s*CLSTB + ROLL_LSB +: 3] = (s == 3) ? 3'd7 : 3'($urandom_range(0, 6));
    @(posedge clock); #1;
    apply_bx(rand_words(), 8'hFF);
    run_cycles(16'h0014, 1'b1, wb, 8'hFF);
    run_cycles(16'h0000, 1'b0, '0, '0);
    chk("roll7_res_vpf_a", 128'(res_vpf_a), 128'(8'hF7));
    chk("roll7_res_vpf_b", 128'(res_vpf_b), 128'(8'hF7));

    // Random sets
    for (int k = 0; k < 8; k++) do_set(rand_words(), 8'($urandom), 16'h0000);

    // Drive the overrun counter into saturation
    for (int k = 0; k < 30; k++) do_set(rand_words(), 8'hFF, 16'h03FE);

    // Reset in the middle of issuing slots 0..5
    @(posedge clock); #1;
    apply_bx(rand_words(), 8'h3F);
    @(posedge clock); #1; bx_start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    cyc = 3;
    reset_n = 1'b0;
    #1;
    chk_cleared("mid");
    ovr_exp = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk_quiet("hold");
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk_quiet("after");
    end
    $display("reset mid-issue sequence complete");

    // Normal operation after the abort
    do_set(rand_words(), 8'($urandom), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gem_cluster_xlat_sched.md
Name: gem_cluster_xlat_sched

Overview:
- Time-multiplexes one shared GEM-cluster-to-CSC translator (pad/roll → 1/8-strip key and wiregroup window) across up to MXCLST GEM clusters captured per BX.
- Sits between the GEM cluster receiver and GEM-CSC matching logic.
- Latches a BX worth of clusters and issues the valid ones to the translator one per clock, skipping invalid slots.
- Tracks translator latency, scatters returned windows back into per-slot result registers, and pulses done when the set is complete.

Parameters:
- MXCLST, 8, cluster slots per BX
- SLOTB, 3, slot index width (log2 MXCLST)
- CLSTB, 14, cluster word width: pad=[7:0], roll=[10:8], size=[13:11]
- WIREBITS, 7, wiregroup width
- MXXKYB, 10, 1/8-strip key width
- XLAT_LAT, 1, translator latency in clocks, input to output (1..4)

Ports:
- clock  in  1  40 MHz logic clock
- reset_n  in  1  asynchronous active-low reset
- bx_start  in  1  load strobe, one cycle per BX
- clst_in  in  MXCLST*CLSTB  packed cluster words, slot i at [i*CLSTB +: CLSTB]
- clst_vpf_in  in  MXCLST  per-slot valid
- xl_cluster  out  CLSTB  cluster word to translator
- xl_vpf  out  1  translator input valid
- xl_roll  out  3  roll field
- xl_pad  out  8  pad field
- xl_size  out  3  size field
- xl_vpf_ret  in  1  translator output valid (gated by ME1a/ME1b enables)
- xl_me1a  in  1  translator ME1a flag
- xl_wire_lo / xl_wire_hi / xl_wire_mi  in  WIREBITS each  wiregroup window
- xl_xky_lo / xl_xky_hi / xl_xky_mi  in  MXXKYB each  key window
- res_vpf  out  MXCLST  per-slot result valid
- res_me1a  out  MXCLST  per-slot ME1a flag
- res_wire_lo / res_wire_hi / res_wire_mi  out  MXCLST*WIREBITS  packed per slot
- res_xky_lo / res_xky_hi / res_xky_mi  out  MXCLST*MXXKYB  packed per slot
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- overrun_cnt  out  8  saturating count of dropped bx_start

Behaviour:
- Reset: async on reset_n low. State IDLE. All res_*, pending mask, latency pipe, xl_*, done, busy and overrun_cnt go to 0. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE + bx_start:
  - Latch clst_in into slot registers and set pending = clst_vpf_in.
  - Clear all res_* to 0.
  - Next state is ISSUE if pending ≠ 0, else DONE.
- DONE state accepts bx_start exactly like IDLE; otherwise it returns to IDLE.
- ISSUE, each cycle:
  - Select s = lowest set bit of pending.
  - Drive xl_vpf=1 and xl_cluster/roll/pad/size from slot s, then clear pending[s].
  - Push {1,s} into an XLAT_LAT-deep shift pipe.
  - When the pending mask after clearing is 0, go to DRAIN.
- DRAIN: hold until the pipe holds no valid entry, then go to DONE.
- Capture: when the pipe tail is valid with slot t, register res_*[t] ← xl_* returns and res_vpf[t] ← xl_vpf_ret, in the same clock edge the tail leaves the pipe. Un-issued slots keep res_vpf = 0.
- xl_* outputs are 0, with xl_vpf=0, in every cycle not issuing.
- done = 1 for exactly the one cycle spent in DONE. busy = (state ≠ IDLE).
- Latency: bx_start at cycle 0 with N valid slots:
  - Issues in cycles 1..N.
  - Last capture at end of cycle N+XLAT_LAT.
  - DONE in cycle N+XLAT_LAT+1.
  - N=0 gives DONE in cycle 1.
- bx_start in ISSUE/DRAIN: ignored. Current set continues unaffected, overrun_cnt += 1, saturating at 255.
- Results hold until the next accepted bx_start.
- A slot valid in clst_vpf_in is issued exactly once per accepted bx_start, in ascending slot order.

Decomposition:
- Shared package gem_xlat_pkg holds:
  - Cluster field offsets (PAD_LSB=0, ROLL_LSB=8, SIZE_LSB=11), CLSTB, WIREBITS, MXXKYB, MXCLST.
  - FSM state encoding.
  - Packed result-record typedef {vpf, me1a, wire lo/hi/mi, xky lo/hi/mi}.
- One natural sub-module: gem_xlat_slot_pipe, the parameterized XLAT_LAT-deep valid+slot-index delay line.
- Priority encoder stays inline.

Test Plan:
- Reset mid-ISSUE (slots 0–5 valid, reset_n low in cycle 3) → all outputs 0 immediately, no done, IDLE after release.
- clst_vpf_in=8'b1000_0101, translator model returns xky_lo=slot*16, XLAT_LAT=1 → issues slots 0,2,7 in cycles 1–3, res_xky_lo slots 0/2/7 = 0/32/112, res_vpf=8'h85, done in cycle 5.
- clst_vpf_in=0 with bx_start → done in cycle 1, res_vpf=0, xl_vpf never asserted.
- All 8 slots valid, XLAT_LAT=3 → 8 consecutive issue cycles, done in cycle 12, each slot holds its own translator return.
- bx_start repeated in cycles 2 and 4 of an 8-slot set → overrun_cnt=2, first set completes unchanged; bx_start in the DONE cycle → new set loaded, busy stays high.
- Translator returns xl_vpf_ret=0 for slot 3 (ME1a disabled, roll 7) → res_vpf[3]=0 while the other slots are valid.
